// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver producing the 11-bit toggle-style ps2_key event word
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RECV, STOP} state_t;

  logic [1:0]     clk_sync_q, dat_sync_q;
  logic [7:0]     filt_cnt_q, filt_cnt_d;
  logic           filt_q, filt_d, filt_prev_q;
  state_t         state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [8:0]     shift_q, shift_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           ext_q, ext_d, rel_q, rel_d;
  logic [2:0]     skip_q, skip_d;
  logic [10:0]    key_q, key_d;
  logic           err_q, err_d;
  logic           fall, data_bit, byte_ok, abort;
  logic [7:0]     rx_byte;

  // Filtered level only follows the synchronised clock after FILTER_LEN agreeing samples
  always_comb begin
    filt_cnt_d = '0;
    filt_d     = filt_q;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == 8'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
      else filt_cnt_d = filt_cnt_q + 8'd1;
    end
  end

  assign fall     = filt_prev_q & ~filt_q;
  assign data_bit = dat_sync_q[1];
  assign rx_byte  = shift_q[7:0];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wd_d      = wd_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    skip_d    = skip_q;
    key_d     = key_q;
    err_d     = 1'b0;
    byte_ok   = 1'b0;
    abort     = 1'b0;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (fall && !data_bit) begin
          state_d   = RECV;
          bit_cnt_d = 4'd0;
        end
      end
      RECV: begin
        if (fall) begin
          wd_d      = '0;
          shift_d   = {data_bit, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) state_d = STOP;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      STOP: begin
        if (fall) begin
          wd_d    = '0;
          state_d = IDLE;
          if (data_bit && (^shift_q)) byte_ok = 1'b1;
          else abort = 1'b1;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      wd_d    = '0;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
    end

    // Pause sequence is E1 plus seven more bytes, none of which may disturb the prefix flags
    if (byte_ok) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (rx_byte == 8'hE1) begin
        skip_d = 3'd7;
      end else if (rx_byte == 8'hE0) begin
        ext_d = 1'b1;
      end else if (rx_byte == 8'hF0) begin
        rel_d = 1'b1;
      end else if (!ext_q && !rel_q &&
                   (rx_byte inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF})) begin
        key_d = key_q;
      end else begin
        key_d = {~key_q[10], ~rel_q, ext_q, rx_byte};
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_cnt_q  <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wd_q        <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      skip_q      <= '0;
      key_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], ps2_data};
      filt_cnt_q  <= filt_cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wd_q        <= wd_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      skip_q      <= skip_d;
      key_q       <= key_d;
      err_q       <= err_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule
